trace_commit_serializer: RTL and testbench

Sits between the superscalar commit stage and the single-port instruction tracer in the testbench. It collects up to NUM_PORTS retired-instruction records per cycle into a FIFO in program order (slot 0 oldest). It replays them one at a time on the tracer port. Each record is presented as a one-cycle valid pulse separated by a mandatory low cycle, because the tracer samples on the rising edge of valid.

---
 rtl/trace_commit_serializer.sv | 191 +++++++++++++++++++
 tb/tb_trace_commit_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_commit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : trace_commit_serializer
// Description : Collects up to NUM_PORTS retired-instruction records per cycle
//               into a FIFO in program order (slot 0 oldest) and replays them
//               one at a time to a single-port tracer. Each record appears as
//               a one-cycle tr_valid_o pulse followed by at least one low cycle.
// Ports       : clk_i, rst_ni            clock / async active-low reset
//               trace_en_i               accept new commit groups when high
//               cm_*_i                   per-slot commit record fields
//               tr_*_o                   serialized record to the tracer
//               almost_full_o            registered; free entries < NUM_PORTS
//               overflow_o               sticky; a commit group was dropped
//               drop_cnt_o               saturating count of dropped records
//               level_o                  current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module trace_commit_serializer #(
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       trace_en_i,
    input  logic [NUM_PORTS-1:0]       cm_valid_i,
    input  logic [32*NUM_PORTS-1:0]    cm_pc_i,
    input  logic [32*NUM_PORTS-1:0]    cm_instr_i,
    input  logic [32*NUM_PORTS-1:0]    cm_reg_data_i,
    input  logic [32*NUM_PORTS-1:0]    cm_mem_addr_i,
    input  logic [32*NUM_PORTS-1:0]    cm_mem_data_i,
    input  logic [32*NUM_PORTS-1:0]    cm_fpu_flags_i,
    input  logic [5*NUM_PORTS-1:0]     cm_reg_addr_i,
    input  logic [2*NUM_PORTS-1:0]     cm_mem_size_i,
    input  logic [NUM_PORTS-1:0]       cm_is_load_i,
    input  logic [NUM_PORTS-1:0]       cm_is_store_i,
    input  logic [NUM_PORTS-1:0]       cm_is_float_i,
    output logic                       tr_valid_o,
    output logic [31:0]                tr_pc_o,
    output logic [31:0]                tr_instr_o,
    output logic [31:0]                tr_reg_data_o,
    output logic [31:0]                tr_mem_addr_o,
    output logic [31:0]                tr_mem_data_o,
    output logic [31:0]                tr_fpu_flags_o,
    output logic [4:0]                 tr_reg_addr_o,
    output logic [1:0]                 tr_mem_size_o,
    output logic                       tr_is_load_o,
    output logic                       tr_is_store_o,
    output logic                       tr_is_float_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 6*32 + 5 + 2 + 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Record layout: {pc, instr, reg_data, mem_addr, mem_data, fpu_flags,
    //                 reg_addr, mem_size, is_load, is_store, is_float}
    logic [REC_W-1:0] slot_rec [NUM_PORTS];

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] mem_d [DEPTH];
    logic [REC_W-1:0] rec_q, rec_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       state_q, state_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [LVL_W-1:0] n_valid;
    logic [LVL_W-1:0] free_cnt;
    logic [LVL_W-1:0] wr_off;
    logic [16:0]      drop_sum;
    logic             group_hit;
    logic             accept;
    logic             drop;
    logic             pop;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            assign slot_rec[gi] = {cm_pc_i[32*gi +: 32],
                                   cm_instr_i[32*gi +: 32],
                                   cm_reg_data_i[32*gi +: 32],
                                   cm_mem_addr_i[32*gi +: 32],
                                   cm_mem_data_i[32*gi +: 32],
                                   cm_fpu_flags_i[32*gi +: 32],
                                   cm_reg_addr_i[5*gi +: 5],
                                   cm_mem_size_i[2*gi +: 2],
                                   cm_is_load_i[gi],
                                   cm_is_store_i[gi],
                                   cm_is_float_i[gi]};
        end
    endgenerate

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            n_valid = n_valid + LVL_W'(cm_valid_i[i]);
        end

        // Acceptance is judged on occupancy before this edge's pop, so a full
        // FIFO drops a group even while an entry is leaving.
        free_cnt  = LVL_W'(DEPTH) - level_q;
        group_hit = trace_en_i && (n_valid != '0);
        accept    = group_hit && (n_valid <= free_cnt);
        drop      = group_hit && !accept;

        // Leaving EMIT always spends one cycle in GAP, so a pop can only
        // happen from IDLE or GAP.
        pop = (state_q != ST_EMIT) && (level_q != '0);

        // Compact valid slots into consecutive FIFO entries, oldest first.
        mem_d  = mem_q;
        wr_off = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept && cm_valid_i[i]) begin
                mem_d[wr_ptr_q + wr_off[PTR_W-1:0]] = slot_rec[i];
                wr_off = wr_off + LVL_W'(1);
            end
        end

        wr_ptr_d = accept ? (wr_ptr_q + n_valid[PTR_W-1:0]) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        level_d  = level_q + (accept ? n_valid : '0) - (pop ? LVL_W'(1) : '0);

        almost_full_d = (LVL_W'(DEPTH) - level_d) < LVL_W'(NUM_PORTS);
        overflow_d    = overflow_q | drop;

        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_valid);
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end

        rec_d = pop ? mem_q[rd_ptr_q] : rec_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (level_q != '0) ? ST_EMIT : ST_IDLE;
            ST_EMIT: state_d = ST_GAP;
            ST_GAP:  state_d = (level_q != '0) ? ST_EMIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rec_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            state_q       <= ST_IDLE;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            rec_q         <= rec_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            state_q       <= state_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign tr_valid_o    = (state_q == ST_EMIT);
    assign {tr_pc_o, tr_instr_o, tr_reg_data_o, tr_mem_addr_o, tr_mem_data_o,
            tr_fpu_flags_o, tr_reg_addr_o, tr_mem_size_o, tr_is_load_o,
            tr_is_store_o, tr_is_float_o} = rec_q;
    assign almost_full_o = almost_full_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign level_o       = level_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_commit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_commit_serializer
// Description : Self-checking bench for trace_commit_serializer. A queue-based
//               reference model tracks FIFO contents, drops and pulse timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_commit_serializer;

    localparam int NP    = 3;
    localparam int DEPTH = 16;
    localparam int RW    = 202;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              trace_en_i;
    logic [NP-1:0]     cm_valid_i;
    logic [32*NP-1:0]  cm_pc_i, cm_instr_i, cm_reg_data_i, cm_mem_addr_i, cm_mem_data_i, cm_fpu_flags_i;
    logic [5*NP-1:0]   cm_reg_addr_i;
    logic [2*NP-1:0]   cm_mem_size_i;
    logic [NP-1:0]     cm_is_load_i, cm_is_store_i, cm_is_float_i;
    logic              tr_valid_o;
    logic [31:0]       tr_pc_o, tr_instr_o, tr_reg_data_o, tr_mem_addr_o, tr_mem_data_o, tr_fpu_flags_o;
    logic [4:0]        tr_reg_addr_o;
    logic [1:0]        tr_mem_size_o;
    logic              tr_is_load_o, tr_is_store_o, tr_is_float_o;
    logic              almost_full_o, overflow_o;
    logic [15:0]       drop_cnt_o;
    logic [4:0]        level_o;

    trace_commit_serializer #(.NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .trace_en_i(trace_en_i), .cm_valid_i(cm_valid_i),
        .cm_pc_i(cm_pc_i), .cm_instr_i(cm_instr_i), .cm_reg_data_i(cm_reg_data_i),
        .cm_mem_addr_i(cm_mem_addr_i), .cm_mem_data_i(cm_mem_data_i), .cm_fpu_flags_i(cm_fpu_flags_i),
        .cm_reg_addr_i(cm_reg_addr_i), .cm_mem_size_i(cm_mem_size_i), .cm_is_load_i(cm_is_load_i),
        .cm_is_store_i(cm_is_store_i), .cm_is_float_i(cm_is_float_i),
        .tr_valid_o(tr_valid_o), .tr_pc_o(tr_pc_o), .tr_instr_o(tr_instr_o),
        .tr_reg_data_o(tr_reg_data_o), .tr_mem_addr_o(tr_mem_addr_o), .tr_mem_data_o(tr_mem_data_o),
        .tr_fpu_flags_o(tr_fpu_flags_o), .tr_reg_addr_o(tr_reg_addr_o), .tr_mem_size_o(tr_mem_size_o),
        .tr_is_load_o(tr_is_load_o), .tr_is_store_o(tr_is_store_o), .tr_is_float_o(tr_is_float_o),
        .almost_full_o(almost_full_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    wire [RW-1:0] obs_rec = {tr_pc_o, tr_instr_o, tr_reg_data_o, tr_mem_addr_o, tr_mem_data_o,
                             tr_fpu_flags_o, tr_reg_addr_o, tr_mem_size_o, tr_is_load_o,
                             tr_is_store_o, tr_is_float_o};

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [RW-1:0] mq[$];
    logic [RW-1:0] m_rec;
    bit            m_valid, m_emit, m_ovf, m_af;
    int            m_drop;

    function automatic logic [RW-1:0] rec_of(int i);
        return {cm_pc_i[32*i +: 32], cm_instr_i[32*i +: 32], cm_reg_data_i[32*i +: 32],
                cm_mem_addr_i[32*i +: 32], cm_mem_data_i[32*i +: 32], cm_fpu_flags_i[32*i +: 32],
                cm_reg_addr_i[5*i +: 5], cm_mem_size_i[2*i +: 2], cm_is_load_i[i],
                cm_is_store_i[i], cm_is_float_i[i]};
    endfunction

    task automatic clear_inputs();
        trace_en_i = 1'b1;    cm_valid_i = '0;
        cm_pc_i = '0;         cm_instr_i = '0;     cm_reg_data_i = '0;
        cm_mem_addr_i = '0;   cm_mem_data_i = '0;  cm_fpu_flags_i = '0;
        cm_reg_addr_i = '0;   cm_mem_size_i = '0;
        cm_is_load_i = '0;    cm_is_store_i = '0;  cm_is_float_i = '0;
    endtask

    task automatic rand_slot(int i);
        cm_pc_i[32*i +: 32]        = $urandom;
        cm_instr_i[32*i +: 32]     = $urandom;
        cm_reg_data_i[32*i +: 32]  = $urandom;
        cm_mem_addr_i[32*i +: 32]  = $urandom;
        cm_mem_data_i[32*i +: 32]  = $urandom;
        cm_fpu_flags_i[32*i +: 32] = $urandom;
        cm_reg_addr_i[5*i +: 5]    = 5'($urandom);
        cm_mem_size_i[2*i +: 2]    = 2'($urandom);
        cm_is_load_i[i]            = 1'($urandom);
        cm_is_store_i[i]           = 1'($urandom);
        cm_is_float_i[i]           = 1'($urandom);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rec = '0; m_valid = 0; m_emit = 0; m_ovf = 0; m_af = 0; m_drop = 0;
    endtask

    // Advance one clock and update the model from the inputs present at the edge.
    // A record is popped only if the queue was non-empty before the edge and the
    // previous cycle was not itself a pulse; groups are judged on pre-pop space.
    task automatic cycle();
        logic [RW-1:0] grp[$];
        int  pre;
        bit  pop;
        grp.delete();
        if (trace_en_i) begin
            for (int i = 0; i < NP; i++) if (cm_valid_i[i]) grp.push_back(rec_of(i));
        end
        pre = mq.size();
        pop = (pre > 0) && !m_emit;
        @(posedge clk_i);
        if (pop) m_rec = mq.pop_front();
        if (grp.size() > 0) begin
            if (grp.size() > DEPTH - pre) begin
                m_ovf  = 1;
                m_drop = (m_drop + grp.size() > 65535) ? 65535 : m_drop + grp.size();
            end else begin
                foreach (grp[k]) mq.push_back(grp[k]);
            end
        end
        m_valid = pop;
        m_emit  = pop;
        m_af    = (DEPTH - mq.size()) < NP;
        #1;
    endtask

    task automatic test_reset();
        total++; if (tr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", tr_valid_o); end
        total++; if (obs_rec !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", obs_rec); end
        total++; if (level_o !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        total++; if ({almost_full_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {almost_full_o, overflow_o}); end
        total++; if (drop_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
    endtask

    task automatic test_single();
        clear_inputs();
        cm_valid_i = 3'b001;
        cm_pc_i[31:0] = 32'h8000_0000; cm_instr_i[31:0] = 32'h0050_0093;
        cm_reg_addr_i[4:0] = 5'd1;     cm_reg_data_i[31:0] = 32'd5;
        cycle();
        clear_inputs();
        total++; if (level_o !== 5'd1 || tr_valid_o !== 1'b0) begin bad++; $display("FAIL single_E0 level=%0d valid=%0b exp level=1 valid=0", level_o, tr_valid_o); end
        cycle();
        total++; if (tr_valid_o !== 1'b1) begin bad++; $display("FAIL single_E1_valid got=%0b exp=1", tr_valid_o); end
        total++; if (tr_pc_o !== 32'h8000_0000 || tr_instr_o !== 32'h0050_0093 || tr_reg_addr_o !== 5'd1 || tr_reg_data_o !== 32'd5)
            begin bad++; $display("FAIL single_fields pc=%h instr=%h rd=%0d data=%0d exp 80000000/00500093/1/5", tr_pc_o, tr_instr_o, tr_reg_addr_o, tr_reg_data_o); end
        total++; if (level_o !== 5'd0) begin bad++; $display("FAIL single_level got=%0d exp=0", level_o); end
        cycle();
        total++; if (tr_valid_o !== 1'b0 || tr_pc_o !== 32'h8000_0000) begin bad++; $display("FAIL single_E2 valid=%0b pc=%h exp valid=0 pc held", tr_valid_o, tr_pc_o); end
    endtask

    task automatic test_gap_group();
        int pulses = 0;
        clear_inputs();
        cm_valid_i = 3'b101;
        cm_pc_i[31:0] = 32'h100; cm_pc_i[63:32] = 32'h104; cm_pc_i[95:64] = 32'h108;
        for (int c = 0; c < 8; c++) begin
            cycle();
            clear_inputs();
            if (tr_valid_o) pulses++;
            if (c == 1) begin
                total++; if (tr_valid_o !== 1'b1 || tr_pc_o !== 32'h100) begin bad++; $display("FAIL gap_first valid=%0b pc=%h exp 1/100", tr_valid_o, tr_pc_o); end
            end
            if (c == 3) begin
                total++; if (tr_valid_o !== 1'b1 || tr_pc_o !== 32'h108) begin bad++; $display("FAIL gap_second valid=%0b pc=%h exp 1/108", tr_valid_o, tr_pc_o); end
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_overflow();
        int c = 0;
        while (c < 200 && (c < 8 || mq.size() > 0 || m_emit)) begin
            clear_inputs();
            if (c < 8) begin
                cm_valid_i = 3'b111;
                for (int i = 0; i < NP; i++) rand_slot(i);
            end
            cycle();
            total++; if (tr_valid_o !== m_valid || obs_rec !== m_rec) begin bad++; $display("FAIL ovf_rec c=%0d valid=%0b rec=%h exp valid=%0b rec=%h", c, tr_valid_o, obs_rec, m_valid, m_rec); end
            total++; if (level_o !== 5'(mq.size()) || almost_full_o !== m_af) begin bad++; $display("FAIL ovf_level c=%0d level=%0d af=%0b exp %0d/%0b", c, level_o, almost_full_o, mq.size(), m_af); end
            total++; if (overflow_o !== m_ovf || drop_cnt_o !== 16'(m_drop)) begin bad++; $display("FAIL ovf_drop c=%0d ovf=%0b cnt=%0d exp %0b/%0d", c, overflow_o, drop_cnt_o, m_ovf, m_drop); end
            c++;
        end
        total++; if (c >= 200) begin bad++; $display("FAIL ovf_drain_timeout level=%0d exp=0", level_o); end
        total++; if (drop_cnt_o !== 16'd6 || overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_total cnt=%0d ovf=%0b exp 6/1", drop_cnt_o, overflow_o); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        int k = 0;
        int c = 0;
        while (c < 200 && (k < 40 || mq.size() > 0 || m_emit)) begin
            clear_inputs();
            if (c % 2 == 0 && k < 40) begin
                cm_valid_i = 3'b001;
                rand_slot(0);
                cm_pc_i[31:0] = 32'h1000 + 32'(4*k);
                k++;
            end
            cycle();
            if (tr_valid_o) pulses++;
            total++; if (tr_valid_o !== m_valid || obs_rec !== m_rec) begin bad++; $display("FAIL wrap_rec c=%0d valid=%0b pc=%h exp valid=%0b pc=%h", c, tr_valid_o, tr_pc_o, m_valid, m_rec[RW-1 -: 32]); end
            total++; if (level_o > 5'd2 || level_o !== 5'(mq.size())) begin bad++; $display("FAIL wrap_level c=%0d got=%0d exp=%0d (max 2)", c, level_o, mq.size()); end
            c++;
        end
        total++; if (pulses != 40) begin bad++; $display("FAIL wrap_pulses got=%0d exp=40", pulses); end
    endtask

    task automatic test_store();
        clear_inputs();
        cm_valid_i = 3'b010;
        cm_pc_i[63:32] = 32'h200; cm_is_store_i[1] = 1'b1; cm_mem_size_i[3:2] = 2'b00;
        cm_mem_addr_i[63:32] = 32'h2000; cm_mem_data_i[63:32] = 32'hAB; cm_reg_addr_i[9:5] = 5'd0;
        cycle();
        clear_inputs();
        cycle();
        total++; if (tr_valid_o !== 1'b1 || tr_is_store_o !== 1'b1 || tr_is_load_o !== 1'b0 || tr_is_float_o !== 1'b0)
            begin bad++; $display("FAIL store_flags valid=%0b st=%0b ld=%0b fp=%0b exp 1/1/0/0", tr_valid_o, tr_is_store_o, tr_is_load_o, tr_is_float_o); end
        total++; if (tr_mem_addr_o !== 32'h2000 || tr_mem_data_o !== 32'hAB || tr_mem_size_o !== 2'b00 || tr_pc_o !== 32'h200)
            begin bad++; $display("FAIL store_fields addr=%h data=%h size=%b pc=%h exp 2000/ab/00/200", tr_mem_addr_o, tr_mem_data_o, tr_mem_size_o, tr_pc_o); end
        cycle();
    endtask

    task automatic test_random();
        int c = 0;
        while (c < 400 && (c < 300 || mq.size() > 0 || m_emit)) begin
            clear_inputs();
            if (c < 300) begin
                trace_en_i = ($urandom_range(0, 7) != 0);
                cm_valid_i = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
                for (int i = 0; i < NP; i++) rand_slot(i);
            end
            cycle();
            total++; if (tr_valid_o !== m_valid || obs_rec !== m_rec) begin bad++; $display("FAIL rnd_rec c=%0d valid=%0b rec=%h exp valid=%0b rec=%h", c, tr_valid_o, obs_rec, m_valid, m_rec); end
            total++; if (level_o !== 5'(mq.size()) || almost_full_o !== m_af) begin bad++; $display("FAIL rnd_level c=%0d level=%0d af=%0b exp %0d/%0b", c, level_o, almost_full_o, mq.size(), m_af); end
            total++; if (overflow_o !== m_ovf || drop_cnt_o !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop c=%0d ovf=%0b cnt=%0d exp %0b/%0d", c, overflow_o, drop_cnt_o, m_ovf, m_drop); end
            c++;
        end
        total++; if (c >= 400) begin bad++; $display("FAIL rnd_drain_timeout level=%0d exp=0", level_o); end
    endtask

    task automatic test_reset_mid_emit();
        clear_inputs();
        cm_valid_i = 3'b111;
        for (int i = 0; i < NP; i++) rand_slot(i);
        cycle();
        for (int i = 0; i < NP; i++) rand_slot(i);
        cycle();
        clear_inputs();
        total++; if (tr_valid_o !== 1'b1 || level_o !== 5'd5) begin bad++; $display("FAIL rstmid_setup valid=%0b level=%0d exp 1/5", tr_valid_o, level_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (tr_valid_o !== 1'b0 || obs_rec !== '0) begin bad++; $display("FAIL rstmid_async valid=%0b rec=%h exp 0/0", tr_valid_o, obs_rec); end
        total++; if (level_o !== 5'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0 || almost_full_o !== 1'b0)
            begin bad++; $display("FAIL rstmid_state level=%0d ovf=%0b cnt=%0d af=%0b exp all 0", level_o, overflow_o, drop_cnt_o, almost_full_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            cycle();
            total++; if (tr_valid_o !== 1'b0 || level_o !== 5'd0) begin bad++; $display("FAIL rstmid_quiet c=%0d valid=%0b level=%0d exp 0/0", c, tr_valid_o, level_o); end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        test_reset();
        test_single();
        test_gap_group();
        test_overflow();
        test_wrap();
        test_store();
        test_random();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
